// File: rtl/compile_guard_monitor.sv
// Valid/ready pass-through with a protocol monitor that flags dropped valid,
// data changing while stalled, and transfers pending longer than TIMEOUT.
module compile_guard_monitor #(
    parameter int WIDTH     = 8,
    parameter int TIMEOUT   = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 EN,
    input  logic                 CLR,
    input  logic                 I_valid,
    input  logic [WIDTH-1:0]     I_data,
    output logic                 I_ready,
    output logic                 O_valid,
    output logic [WIDTH-1:0]     O_data,
    input  logic                 O_ready,
    output logic                 err,
    output logic [1:0]           err_code,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic                 stall
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    localparam logic [7:0]           TO_LIM  = 8'(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WIDTH-1:0]     r_cap;
    logic [WIDTH-1:0]     w_cap_nxt;
    logic [7:0]           r_wait;
    logic [7:0]           w_wait_nxt;
    logic [7:0]           w_wait_inc;
    logic                 r_to_done;
    logic                 w_to_done_nxt;
    logic                 r_stall;
    logic                 w_stall_nxt;
    logic                 w_chg;
    logic                 w_viol;
    logic [1:0]           w_vcode;

    logic                 r_err;
    logic                 w_err_nxt;
    logic [1:0]           r_code;
    logic [1:0]           w_code_nxt;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic                 w_err_base;
    logic [1:0]           w_code_base;
    logic [CNT_WIDTH-1:0] w_cnt_base;

    assign O_valid = I_valid;
    assign O_data  = I_data;
    assign I_ready = O_ready;

    assign err       = r_err;
    assign err_code  = r_code;
    assign err_count = r_cnt;
    assign stall     = r_stall;

    assign w_wait_inc = (r_wait == 8'hFF) ? 8'hFF : r_wait + 8'd1;
    assign w_chg      = (I_data != r_cap);

    always_comb begin
        w_state_nxt   = IDLE;
        w_cap_nxt     = r_cap;
        w_wait_nxt    = 8'd0;
        w_to_done_nxt = 1'b0;
        w_viol        = 1'b0;
        w_vcode       = 2'd0;
        if (EN) begin
            case (r_state)
                IDLE: begin
                    if (I_valid && !O_ready) begin
                        w_state_nxt = PEND;
                        w_cap_nxt   = I_data;
                        w_wait_nxt  = 8'd1;
                    end
                end
                PEND: begin
                    if (!I_valid) begin
                        w_viol  = 1'b1;
                        w_vcode = 2'd1;
                    end else begin
                        w_to_done_nxt = r_to_done;
                        if (w_chg) begin
                            w_viol    = 1'b1;
                            w_vcode   = 2'd2;
                            w_cap_nxt = I_data;
                        end
                        if (!O_ready) begin
                            w_state_nxt = PEND;
                            w_wait_nxt  = w_wait_inc;
                            // A timeout masked by a data change retries next cycle
                            if (w_wait_inc >= TO_LIM && !r_to_done && !w_chg) begin
                                w_viol        = 1'b1;
                                w_vcode       = 2'd3;
                                w_to_done_nxt = 1'b1;
                            end
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign w_stall_nxt = (w_state_nxt == PEND) && (w_wait_nxt >= TO_LIM);

    always_comb begin
        w_err_base  = CLR ? 1'b0 : r_err;
        w_code_base = CLR ? 2'd0 : r_code;
        w_cnt_base  = CLR ? '0 : r_cnt;
        w_err_nxt   = w_err_base;
        w_code_nxt  = w_code_base;
        w_cnt_nxt   = w_cnt_base;
        if (w_viol) begin
            w_err_nxt = 1'b1;
            if (w_cnt_base == '0)
                w_code_nxt = w_vcode;
            if (!(&w_cnt_base))
                w_cnt_nxt = w_cnt_base + CNT_ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= IDLE;
            r_cap     <= '0;
            r_wait    <= 8'd0;
            r_to_done <= 1'b0;
            r_stall   <= 1'b0;
            r_err     <= 1'b0;
            r_code    <= 2'd0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cap     <= w_cap_nxt;
            r_wait    <= w_wait_nxt;
            r_to_done <= w_to_done_nxt;
            r_stall   <= w_stall_nxt;
            r_err     <= w_err_nxt;
            r_code    <= w_code_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_compile_guard_monitor.sv
// Scoreboard bench: each driven cycle queues the expected post-edge outputs,
// a monitor pops and compares one entry shortly after every rising edge.
module tb_compile_guard_monitor;

    logic       CLK = 1'b0;
    logic       RESET, EN, CLR, I_valid, O_ready;
    logic [7:0] I_data;
    logic       I_ready, O_valid, err, stall;
    logic [7:0] O_data;
    logic [1:0] err_code;
    logic [1:0] err_count;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       e;
        logic [1:0] c;
        logic [1:0] n;
        logic       s;
        string      nm;
    } exp_t;

    exp_t q[$];

    compile_guard_monitor #(
        .WIDTH(8),
        .TIMEOUT(4),
        .CNT_WIDTH(2)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .EN(EN),
        .CLR(CLR),
        .I_valid(I_valid),
        .I_data(I_data),
        .I_ready(I_ready),
        .O_valid(O_valid),
        .O_data(O_data),
        .O_ready(O_ready),
        .err(err),
        .err_code(err_code),
        .err_count(err_count),
        .stall(stall)
    );

    always #5 CLK = ~CLK;

    task automatic cyc(input logic rst, input logic en, input logic clr,
                       input logic v, input logic [7:0] d, input logic rdy,
                       input logic e, input logic [1:0] c,
                       input logic [1:0] n, input logic s, input string nm);
        exp_t x;
        @(negedge CLK);
        RESET   = rst;
        EN      = en;
        CLR     = clr;
        I_valid = v;
        I_data  = d;
        O_ready = rdy;
        x.e = e; x.c = c; x.n = n; x.s = s; x.nm = nm;
        q.push_back(x);
    endtask

    task automatic p(input logic v, input logic [7:0] d, input logic rdy,
                     input logic e, input logic [1:0] c,
                     input logic [1:0] n, input logic s, input string nm);
        cyc(1'b0, 1'b1, 1'b0, v, d, rdy, e, c, n, s, nm);
    endtask

    task automatic clr_cyc(input string nm);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, nm);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge CLK);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                n_tests++;
                if (O_valid !== I_valid || O_data !== I_data || I_ready !== O_ready) begin
                    n_fail++;
                    $display("FAIL %s_pass: ov=%b od=%h ir=%b, expected ov=%b od=%h ir=%b",
                             x.nm, O_valid, O_data, I_ready, I_valid, I_data, O_ready);
                end
                n_tests++;
                if (err !== x.e || err_code !== x.c || err_count !== x.n || stall !== x.s) begin
                    n_fail++;
                    $display("FAIL %s: err=%b code=%0d cnt=%0d stall=%b, expected err=%b code=%0d cnt=%0d stall=%b",
                             x.nm, err, err_code, err_count, stall, x.e, x.c, x.n, x.s);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [1:0] kn;
        logic [1:0] pn;
        RESET = 1'b1; EN = 1'b0; CLR = 1'b0;
        I_valid = 1'b0; I_data = 8'h00; O_ready = 1'b0;

        cyc(1, 1, 0, 0, 8'h00, 0, 0, 0, 0, 0, "reset0");
        cyc(1, 0, 1, 1, 8'hFF, 0, 0, 0, 0, 0, "reset1");

        p(1, 8'hA5, 0, 0, 0, 0, 0, "clean_p1");
        p(1, 8'hA5, 0, 0, 0, 0, 0, "clean_p2");
        p(1, 8'hA5, 0, 0, 0, 0, 0, "clean_p3");
        p(1, 8'hA5, 1, 0, 0, 0, 0, "clean_done");
        p(0, 8'h00, 0, 0, 0, 0, 0, "clean_idle");

        p(1, 8'h33, 0, 0, 0, 0, 0, "drop_p1");
        p(1, 8'h33, 0, 0, 0, 0, 0, "drop_p2");
        p(0, 8'h33, 0, 1, 1, 1, 0, "drop");
        p(0, 8'h00, 0, 1, 1, 1, 0, "drop_idle");
        clr_cyc("clr_a");

        p(1, 8'h11, 0, 0, 0, 0, 0, "chg_p1");
        p(1, 8'h22, 0, 1, 2, 1, 0, "chg");
        p(1, 8'h22, 1, 1, 2, 1, 0, "chg_done");
        p(0, 8'h00, 0, 1, 2, 1, 0, "chg_idle");
        clr_cyc("clr_b");

        p(1, 8'h5A, 0, 0, 0, 0, 0, "to_w1");
        p(1, 8'h5A, 0, 0, 0, 0, 0, "to_w2");
        p(1, 8'h5A, 0, 0, 0, 0, 0, "to_w3");
        p(1, 8'h5A, 0, 1, 3, 1, 1, "to_hit");
        for (int i = 0; i < 6; i++)
            p(1, 8'h5A, 0, 1, 3, 1, 1, "to_hold");
        p(1, 8'h5A, 1, 1, 3, 1, 0, "to_done");
        p(0, 8'h00, 0, 1, 3, 1, 0, "to_idle");
        clr_cyc("clr_c");

        p(1, 8'h01, 0, 0, 0, 0, 0, "sup_w1");
        p(1, 8'h01, 0, 0, 0, 0, 0, "sup_w2");
        p(1, 8'h01, 0, 0, 0, 0, 0, "sup_w3");
        p(1, 8'h02, 0, 1, 2, 1, 1, "sup_chg");
        p(1, 8'h02, 0, 1, 2, 2, 1, "sup_to");
        p(1, 8'h02, 0, 1, 2, 2, 1, "sup_once");
        p(1, 8'h02, 1, 1, 2, 2, 0, "sup_done");
        clr_cyc("clr_d");

        for (int k = 1; k <= 5; k++) begin
            pn = (k - 1 > 3) ? 2'd3 : 2'(k - 1);
            kn = (k > 3) ? 2'd3 : 2'(k);
            p(1, 8'(k), 0, (k > 1), (k > 1) ? 2'd1 : 2'd0, pn, 0, "sat_pend");
            p(0, 8'(k), 0, 1, 1, kn, 0, "sat_drop");
        end
        p(1, 8'h10, 0, 1, 1, 3, 0, "sat_p");
        cyc(0, 1, 1, 1, 8'h20, 0, 1, 2, 1, 0, "clr_chg");
        p(0, 8'h00, 0, 1, 2, 2, 0, "clr_drop");
        cyc(1, 1, 0, 0, 8'h00, 0, 0, 0, 0, 0, "reset2");

        p(1, 8'h44, 0, 0, 0, 0, 0, "pre_p");
        p(0, 8'h44, 0, 1, 1, 1, 0, "pre_drop");
        p(1, 8'h77, 0, 1, 1, 1, 0, "rm_w1");
        p(1, 8'h77, 0, 1, 1, 1, 0, "rm_w2");
        p(1, 8'h77, 0, 1, 1, 1, 0, "rm_w3");
        cyc(1, 1, 1, 1, 8'h77, 0, 0, 0, 0, 0, "rst_mid");
        p(0, 8'h00, 0, 0, 0, 0, 0, "rst_idle");

        p(1, 8'h44, 0, 0, 0, 0, 0, "en_pre");
        p(0, 8'h44, 0, 1, 1, 1, 0, "en_drop");
        p(1, 8'h88, 0, 1, 1, 1, 0, "en_w1");
        p(1, 8'h88, 0, 1, 1, 1, 0, "en_w2");
        p(1, 8'h88, 0, 1, 1, 1, 0, "en_w3");
        p(1, 8'h88, 0, 1, 1, 2, 1, "en_to");
        cyc(0, 0, 0, 1, 8'h88, 0, 1, 1, 2, 0, "en_off");
        cyc(0, 0, 0, 1, 8'h99, 0, 1, 1, 2, 0, "en_off2");
        cyc(0, 0, 0, 0, 8'h00, 0, 1, 1, 2, 0, "en_off3");
        p(0, 8'h00, 0, 1, 1, 2, 0, "en_back");

        for (int i = 0; i < 10 && q.size() > 0; i++)
            @(posedge CLK);
        #2;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
